// File: rtl/riscv_trace_pkg.sv
// Shared types and constants for the retirement-trace transmitter.
// A record is 18 bytes; byte 0 is the header and all words are little-endian.
package riscv_trace_pkg;

    localparam logic [2:0] TRC_NONE     = 3'd0;
    localparam logic [2:0] TRC_REG_WR   = 3'd1;
    localparam logic [2:0] TRC_MEM_WR   = 3'd2;
    localparam logic [2:0] TRC_BR_TAKEN = 3'd3;
    localparam logic [2:0] TRC_BR_NOT   = 3'd4;
    localparam logic [2:0] TRC_JUMP     = 3'd5;
    localparam logic [2:0] TRC_JAL_LINK = 3'd6;

    localparam int REC_BYTES = 18;

    typedef struct packed {
        logic [2:0]  kind;
        logic [4:0]  seq;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] data;
        logic [31:0] aux;
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

    // Flatten with byte 0 in the least significant position, then pick byte idx.
    function automatic logic [7:0] rec_byte(input trace_rec_t rec, input logic [4:0] idx);
        logic [REC_BYTES*8-1:0] flat;
        flat = {rec.aux, rec.data, rec.instr, rec.pc, 3'b000, rec.rd, rec.kind, rec.seq};
        return flat[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/riscv_trace_fifo.sv
// Synchronous record FIFO; a push into a full FIFO is accepted only when a pop
// happens on the same edge.
module riscv_trace_fifo
    import riscv_trace_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [REC_W-1:0] i_rec,
    input  logic             i_pop,
    output logic [REC_W-1:0] o_rec,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    logic [REC_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == LVL_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rec     = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

    // Storage needs no reset: pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_rec;
    end

endmodule

// File: rtl/riscv_trace_tx.sv
// Retirement-trace transmitter: classifies each sampled commit, queues an 18-byte
// record and serialises records byte-by-byte over a valid/ready port.
module riscv_trace_tx
    import riscv_trace_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 16,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_trace_en,
    input  logic [31:0]       i_pc,
    input  logic [31:0]       i_instr,
    input  logic [31:0]       i_result,
    input  logic [31:0]       i_alu_result,
    input  logic [31:0]       i_rd2,
    input  logic [31:0]       i_pc_next,
    input  logic              i_reg_write,
    input  logic              i_mem_write,
    input  logic              i_branch,
    input  logic              i_jump,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic [DROP_W-1:0] o_drop_count,
    output logic [LW-1:0]     o_fifo_level
);

    localparam logic [4:0] LAST_IDX = 5'(REC_BYTES - 1);

    trace_rec_t       w_rec;
    logic [4:0]       w_rd;
    logic [REC_W-1:0] w_fifo_rec;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_dropped;

    tx_state_e        r_state;
    tx_state_e        w_state_nxt;
    trace_rec_t       r_rec;
    trace_rec_t       w_rec_nxt;
    logic [4:0]       r_idx;
    logic [4:0]       w_idx_nxt;
    logic [4:0]       r_seq;
    logic [DROP_W-1:0] r_drop;

    assign w_rd = i_instr[11:7];

    always_comb begin
        w_rec       = '0;
        w_rec.seq   = r_seq;
        w_rec.rd    = w_rd;
        w_rec.pc    = i_pc;
        w_rec.instr = i_instr;
        if (i_reg_write && w_rd != 5'd0 && i_jump) w_rec.kind = TRC_JAL_LINK;
        else if (i_reg_write && w_rd != 5'd0)      w_rec.kind = TRC_REG_WR;
        else if (i_mem_write)                      w_rec.kind = TRC_MEM_WR;
        else if (i_branch && i_pc_next != i_pc + 32'd4) w_rec.kind = TRC_BR_TAKEN;
        else if (i_branch)                         w_rec.kind = TRC_BR_NOT;
        else if (i_jump)                           w_rec.kind = TRC_JUMP;
        else                                       w_rec.kind = TRC_NONE;

        case (w_rec.kind)
            TRC_REG_WR:   w_rec.data = i_result;
            TRC_JAL_LINK: w_rec.data = i_result;
            TRC_MEM_WR:   w_rec.data = i_rd2;
            default:      w_rec.data = 32'd0;
        endcase
        case (w_rec.kind)
            TRC_MEM_WR:   w_rec.aux = i_alu_result;
            TRC_BR_TAKEN,
            TRC_BR_NOT,
            TRC_JUMP,
            TRC_JAL_LINK: w_rec.aux = i_pc_next;
            default:      w_rec.aux = 32'd0;
        endcase
    end

    riscv_trace_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (i_trace_en),
        .i_rec   (w_rec),
        .i_pop   (w_pop),
        .o_rec   (w_fifo_rec),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_fifo_level)
    );

    // Sequence advances on every sampled event so the receiver can spot drops.
    assign w_dropped = i_trace_en && w_full && !w_pop;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_seq  <= '0;
            r_drop <= '0;
        end else begin
            if (i_trace_en) r_seq <= r_seq + 5'd1;
            if (w_dropped && r_drop != '1) r_drop <= r_drop + 1'b1;
        end
    end

    assign o_drop_count = r_drop;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_rec   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rec   <= w_rec_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rec_nxt   = r_rec;
        w_idx_nxt   = r_idx;
        w_pop       = 1'b0;
        o_tx_valid  = 1'b0;
        o_tx_data   = 8'd0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_rec_nxt   = trace_rec_t'(w_fifo_rec);
                    w_idx_nxt   = 5'd0;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                o_tx_valid = 1'b1;
                o_tx_data  = rec_byte(r_rec, r_idx);
                if (i_tx_ready) begin
                    if (r_idx != LAST_IDX) begin
                        w_idx_nxt = r_idx + 5'd1;
                    end else if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_rec_nxt = trace_rec_t'(w_fifo_rec);
                        w_idx_nxt = 5'd0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_riscv_trace_tx.sv
// Scoreboard bench for riscv_trace_tx: stimulus queues expected bytes, a monitor
// pops and compares each accepted byte.
module tb_riscv_trace_tx;

    localparam int DEPTH  = 4;
    localparam int DROP_W = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trace_en = 1'b0;
    logic [31:0] pc = '0, instr = '0, result = '0, alu_result = '0, rd2 = '0, pc_next = '0;
    logic        reg_write = 1'b0, mem_write = 1'b0, branch = 1'b0, jump = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [DROP_W-1:0] drop_count;
    logic [$clog2(DEPTH):0] fifo_level;

    logic [7:0] exp_q[$];
    logic [4:0] exp_seq = '0;
    int n_cmp = 0;
    int n_err = 0;
    int byte_no = 0;

    always #5 clk = ~clk;

    riscv_trace_tx #(
        .DEPTH(DEPTH),
        .DROP_W(DROP_W)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_trace_en   (trace_en),
        .i_pc         (pc),
        .i_instr      (instr),
        .i_result     (result),
        .i_alu_result (alu_result),
        .i_rd2        (rd2),
        .i_pc_next    (pc_next),
        .i_reg_write  (reg_write),
        .i_mem_write  (mem_write),
        .i_branch     (branch),
        .i_jump       (jump),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .o_drop_count (drop_count),
        .o_fifo_level (fifo_level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs only change 1 time unit after a rising edge, so the negedge view is
    // exactly what the next rising edge will see.
    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL stray_byte: got 0x%0h, expected no byte", tx_data);
            end else begin
                chk($sformatf("byte%0d", byte_no), {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
            byte_no++;
        end
    end

    task automatic push_hex(input logic [143:0] v);
        for (int i = 0; i < 18; i++) exp_q.push_back(v[143 - 8*i -: 8]);
    endtask

    task automatic push_model(input logic [31:0] m_pc, m_instr, m_res, m_alu, m_rd2, m_pcn,
                              input logic m_rw, m_mw, m_br, m_j);
        logic [4:0]  rd;
        logic [2:0]  k;
        logic [31:0] d;
        logic [31:0] a;
        rd = m_instr[11:7];
        if (m_rw && rd != 0 && m_j)          k = 3'd6;
        else if (m_rw && rd != 0)            k = 3'd1;
        else if (m_mw)                       k = 3'd2;
        else if (m_br && m_pcn != m_pc + 4)  k = 3'd3;
        else if (m_br)                       k = 3'd4;
        else if (m_j)                        k = 3'd5;
        else                                 k = 3'd0;
        d = (k == 3'd1 || k == 3'd6) ? m_res : (k == 3'd2) ? m_rd2 : 32'd0;
        a = (k == 3'd2) ? m_alu : (k >= 3'd3 && k <= 3'd6) ? m_pcn : 32'd0;
        exp_q.push_back({k, exp_seq});
        exp_q.push_back({3'b000, rd});
        for (int i = 0; i < 4; i++) exp_q.push_back(m_pc[8*i +: 8]);
        for (int i = 0; i < 4; i++) exp_q.push_back(m_instr[8*i +: 8]);
        for (int i = 0; i < 4; i++) exp_q.push_back(d[8*i +: 8]);
        for (int i = 0; i < 4; i++) exp_q.push_back(a[8*i +: 8]);
    endtask

    // Called just after a rising edge; trace_en is high for exactly the next edge.
    task automatic issue(input logic [31:0] i_pc, i_instr, i_res, i_alu, i_rd2, i_pcn,
                         input logic i_rw, i_mw, i_br, i_j, input bit use_model);
        pc = i_pc; instr = i_instr; result = i_res; alu_result = i_alu; rd2 = i_rd2;
        pc_next = i_pcn; reg_write = i_rw; mem_write = i_mw; branch = i_br; jump = i_j;
        trace_en = 1'b1;
        if (use_model) push_model(i_pc, i_instr, i_res, i_alu, i_rd2, i_pcn, i_rw, i_mw, i_br, i_j);
        @(posedge clk); #1;
        trace_en = 1'b0;
        exp_seq++;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        tx_ready = 1'b1;
        while ((exp_q.size() != 0 || tx_valid) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        chk({name, "_left"}, exp_q.size(), 0);
        chk({name, "_idle"}, {31'd0, tx_valid}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] held;
        int issued;
        int cyc;
        logic [31:0] r_pc;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, tx_valid}, 0);
        chk("rst_data", {24'd0, tx_data}, 0);
        chk("rst_drop", {16'd0, drop_count}, 0);
        chk("rst_level", {29'd0, fifo_level}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // addi x1,x0,5
        tx_ready = 1'b1;
        push_hex(144'h2001_00000000_93005000_05000000_00000000);
        issue(32'h0, 32'h00500093, 32'd5, 32'd5, 32'd0, 32'h4, 1, 0, 0, 0, 0);
        chk("lat_edge_e", {31'd0, tx_valid}, 0);
        @(posedge clk); #1;
        chk("lat_valid", {31'd0, tx_valid}, 1);
        chk("lat_byte0", {24'd0, tx_data}, 32'h20);
        drain("addi");

        // sw x2,8(x0)
        push_hex(144'h4108_10000000_23242000_07000000_08000000);
        issue(32'h10, 32'h00202423, 32'd0, 32'd8, 32'd7, 32'h14, 0, 1, 0, 0, 0);
        drain("sw");

        // taken, not-taken, jal x1, rd=0 write (NONE), jal x0 (JUMP), back to back
        issue(32'h20, 32'h00000463, 32'd0, 32'd0, 32'd0, 32'h28, 0, 0, 1, 0, 1);
        issue(32'h20, 32'h00000463, 32'd0, 32'd0, 32'd0, 32'h24, 0, 0, 1, 0, 1);
        issue(32'h20, 32'h004000EF, 32'h24, 32'd0, 32'd0, 32'h24, 1, 0, 0, 1, 1);
        issue(32'h24, 32'h00000013, 32'h99, 32'd0, 32'd0, 32'h28, 1, 0, 0, 0, 1);
        issue(32'h28, 32'h0080006F, 32'h2C, 32'd0, 32'd0, 32'h30, 1, 0, 0, 1, 1);
        drain("ctrl");
        chk("ctrl_drop", {16'd0, drop_count}, 0);

        // Stall the sink: 1 record held, 4 buffered, 5 dropped
        tx_ready = 1'b0;
        held = 8'h00;
        for (int i = 0; i < 10; i++) begin
            issue(32'h100 + 4*i, 32'h00000013, 32'd0, 32'd0, 32'd0, 32'h104 + 4*i,
                  1, 0, 0, 0, i < 5);
            if (i == 1) held = tx_data;
        end
        chk("stall_level", {29'd0, fifo_level}, DEPTH);
        chk("stall_drop", {16'd0, drop_count}, 5);
        chk("stall_valid", {31'd0, tx_valid}, 1);
        chk("stall_hold", {24'd0, tx_data}, {24'd0, held});
        chk("stall_hdr", {24'd0, tx_data}, 32'h07);
        drain("stall");
        issue(32'h200, 32'h00000013, 32'd0, 32'd0, 32'd0, 32'h204, 0, 0, 0, 0, 1);
        drain("gap");
        chk("gap_drop", {16'd0, drop_count}, 5);

        // Random sink back-pressure, 50 records, never overfilling the FIFO
        issued = 0;
        cyc = 0;
        while (issued < 50 && cyc < 20000) begin
            tx_ready = 1'($urandom_range(0, 1));
            if (fifo_level < 3) begin
                r_pc = $urandom & 32'hFFFF_FFFC;
                pc = r_pc; instr = $urandom; result = $urandom; alu_result = $urandom;
                rd2 = $urandom;
                pc_next = ($urandom_range(0, 1) == 1) ? r_pc + 32'd4 : $urandom;
                reg_write = 1'($urandom_range(0, 1)); mem_write = 1'($urandom_range(0, 1));
                branch = 1'($urandom_range(0, 1)); jump = 1'($urandom_range(0, 1));
                trace_en = 1'b1;
                push_model(pc, instr, result, alu_result, rd2, pc_next,
                           reg_write, mem_write, branch, jump);
                exp_seq++;
                issued++;
            end else begin
                trace_en = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        trace_en = 1'b0;
        chk("rand_issued", issued, 50);
        drain("rand");
        chk("rand_drop", {16'd0, drop_count}, 5);

        // Reset while byte 7 (instr[15:8]) is on the wire
        tx_ready = 1'b1;
        issue(32'h300, 32'h12345693, 32'd1, 32'd0, 32'd0, 32'h304, 1, 0, 0, 0, 1);
        repeat (8) @(posedge clk);
        #1;
        chk("mid_idx7", {24'd0, tx_data}, 32'h56);
        reset = 1'b1;
        exp_q.delete();
        exp_seq = '0;
        #1;
        chk("mid_rst_valid", {31'd0, tx_valid}, 0);
        chk("mid_rst_data", {24'd0, tx_data}, 0);
        chk("mid_rst_level", {29'd0, fifo_level}, 0);
        chk("mid_rst_drop", {16'd0, drop_count}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        issue(32'h400, 32'h00500093, 32'd5, 32'd0, 32'd0, 32'h404, 1, 0, 0, 0, 1);
        @(posedge clk); #1;
        chk("post_rst_hdr", {24'd0, tx_data}, 32'h20);
        drain("post_rst");

        chk("final_queue", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
